// File: rtl/bios_bus_slave_if.sv
// Bus and ROM port bundle for the BIOS ROM slave.
// slave: the BIOS block. master: the bus master plus ROM.
interface bios_bus_slave_if;
  logic        beginTransactionIn;
  logic        endTransactionIn;
  logic        readNotWriteIn;
  logic [31:0] addressDataIn;
  logic [7:0]  burstSizeIn;
  logic [31:0] romData;
  logic [10:0] romAddress;
  logic [31:0] addressDataOut;
  logic        dataValidOut;
  logic        endTransactionOut;
  logic        busErrorOut;

  modport slave (
    input  beginTransactionIn,
    input  endTransactionIn,
    input  readNotWriteIn,
    input  addressDataIn,
    input  burstSizeIn,
    input  romData,
    output romAddress,
    output addressDataOut,
    output dataValidOut,
    output endTransactionOut,
    output busErrorOut
  );

  modport master (
    output beginTransactionIn,
    output endTransactionIn,
    output readNotWriteIn,
    output addressDataIn,
    output burstSizeIn,
    output romData,
    input  romAddress,
    input  addressDataOut,
    input  dataValidOut,
    input  endTransactionOut,
    input  busErrorOut
  );
endinterface

// File: rtl/bios_bus_slave.sv
// Read-only 8 KiB BIOS window on the system bus.
// Serves burst reads from a ROM; writes get a bus error.
module bios_bus_slave #(
  parameter logic [31:0] BASE_ADDR = 32'hF0000000
) (
  input logic        clock,
  input logic        reset,
  bios_bus_slave_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    BURST,
    ENDTX,
    ERROR
  } state_t;

  state_t      state;
  logic [10:0] index;
  logic [7:0]  count;
  logic        valid;
  logic        endtx;
  logic        err;
  logic        hit;
  logic        unused_bits;

  // Byte offset within a word carries no meaning here.
  assign unused_bits = ^bus.addressDataIn[1:0];

  assign hit = bus.addressDataIn[31:13] == BASE_ADDR[31:13];

  assign bus.romAddress        = index;
  assign bus.dataValidOut      = valid;
  assign bus.endTransactionOut = endtx;
  assign bus.busErrorOut       = err;

  // Byte-swap the little-endian ROM word onto the bus; zero when idle.
  always_comb begin
    bus.addressDataOut = '0;
    if (valid) begin
      bus.addressDataOut = {bus.romData[7:0],
                            bus.romData[15:8],
                            bus.romData[23:16],
                            bus.romData[31:24]};
    end
  end

  // Transaction FSM with registered strobes and ROM index.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      index <= '0;
      count <= '0;
      valid <= 1'b0;
      endtx <= 1'b0;
      err   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          endtx <= 1'b0;
          err   <= 1'b0;
          valid <= 1'b0;
          if (bus.beginTransactionIn && hit) begin
            if (bus.readNotWriteIn) begin
              state <= BURST;
              index <= bus.addressDataIn[12:2];
              count <= bus.burstSizeIn;
              valid <= 1'b1;
            end else begin
              state <= ERROR;
              err   <= 1'b1;
            end
          end
        end
        BURST: begin
          if (bus.endTransactionIn) begin
            state <= IDLE;
            valid <= 1'b0;
          end else if (count != 8'd0) begin
            index <= index + 11'd1;
            count <= count - 8'd1;
          end else begin
            state <= ENDTX;
            valid <= 1'b0;
            endtx <= 1'b1;
          end
        end
        ENDTX: begin
          state <= IDLE;
          endtx <= 1'b0;
        end
        ERROR: begin
          state <= IDLE;
          err   <= 1'b0;
        end
        default: begin
          state <= IDLE;
          valid <= 1'b0;
          endtx <= 1'b0;
          err   <= 1'b0;
        end
      endcase
    end
  end

endmodule
